marker_phase_tracker: RTL and testbench

Synthesizable, parametrised successor to the testbench commit-marker monitor. Watches COMMIT_WIDTH retire lanes for marker instructions (`slti x0,x0,imm`), tracks the current test phase and accumulates per-phase cycle counts. Queues decoded events into a ready/valid FIFO for a trace sink and raises delayed-done and sim-exit flags. Sits beside the ROB commit port of the DUT and of the variant core, one instance each.

---
 rtl/marker_pkg.sv | 50 +++++
 rtl/marker_evq.sv | 45 ++++
 rtl/marker_phase_tracker.sv | 186 ++++++++++++++++++
 tb/tb_marker_phase_tracker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/marker_pkg.sv
// Shared types for the retire-port marker tracker: marker codes, phase ids
// and the instruction decoder for `slti x0,x0,imm` markers.
package marker_pkg;

    localparam logic [19:0] MARKER_OPC_LO = 20'h02013;

    typedef enum logic [3:0] {
        MK_VCTM_START  = 4'd0,
        MK_VCTM_END    = 4'd1,
        MK_DELAY_START = 4'd2,
        MK_DELAY_END   = 4'd3,
        MK_TEXE_START  = 4'd4,
        MK_TEXE_END    = 4'd5,
        MK_LEAK_START  = 4'd6,
        MK_LEAK_END    = 4'd7,
        MK_INIT_START  = 4'd8,
        MK_INIT_END    = 4'd9,
        MK_BIM_START   = 4'd10,
        MK_BIM_END     = 4'd11,
        MK_TRAIN_START = 4'd12,
        MK_TRAIN_END   = 4'd13,
        MK_SIM_EXIT    = 4'd14
    } marker_code_e;

    typedef enum logic [2:0] {
        PH_VCTM    = 3'd0,
        PH_DELAY   = 3'd1,
        PH_TEXE    = 3'd2,
        PH_LEAK    = 3'd3,
        PH_INIT    = 3'd4,
        PH_BIM     = 3'd5,
        PH_TRAIN   = 3'd6,
        PHASE_IDLE = 3'd7
    } phase_e;

    typedef struct packed {
        logic       is_marker;
        logic [3:0] code;
    } marker_dec_t;

    // Code 15 shares the encoding but is reserved, so it is not a marker.
    function automatic marker_dec_t marker_decode(input logic [31:0] inst);
        marker_dec_t d;
        d.code      = inst[23:20];
        d.is_marker = (inst[19:0] == MARKER_OPC_LO) && (inst[31:24] == 8'h00)
                      && (inst[23:20] != 4'hF);
        return d;
    endfunction

endpackage

// File: rtl/marker_evq.sv
// Event queue: up to NPUSH writes per edge (compacted, slot 0 first), one pop.
// free_o is the space before this edge's pop; there is no push/pop bypass.
module marker_evq
    import marker_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NPUSH = 4,
    parameter int ENT_W = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [$clog2(NPUSH+1)-1:0]   push_cnt_i,
    input  logic [ENT_W-1:0]             push_data_i [NPUSH],
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [ENT_W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]       free_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PC_W = $clog2(NPUSH+1);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q, count;

    assign count   = wr_q - rd_q;
    assign valid_o = (count != '0);
    assign free_o  = (AW+1)'(DEPTH) - count;
    assign head_o  = valid_o ? mem_q[rd_q[AW-1:0]] : '0;

    // Storage and pointers: write the first push_cnt_i slots, pop the head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
        end else begin
            for (int i = 0; i < NPUSH; i++) begin
                if (PC_W'(i) < push_cnt_i) mem_q[wr_q[AW-1:0] + AW'(i)] <= push_data_i[i];
            end
            wr_q <= wr_q + (AW+1)'(push_cnt_i);
            if (pop_i && valid_o) rd_q <= rd_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/marker_phase_tracker.sv
// Commit-port marker tracker: decodes marker instructions on the retire lanes,
// follows the test phase, accumulates per-phase cycles and queues events.
// Optional build macro MARKER_TIMESTAMP_EN stores a cycle stamp per event.
//
// state      | meaning
// PH_VCTM..  | inside phase 0..6, accumulator of that phase counts
// PHASE_IDLE | no phase open, nothing accumulates
module marker_phase_tracker
    import marker_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int CNT_W        = 32,
    parameter int EVQ_DEPTH    = 8,
    parameter int DONE_DELAY   = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [COMMIT_WIDTH-1:0]           commit_valid,
    input  logic [32*COMMIT_WIDTH-1:0]        commit_inst,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [3:0]                        evt_code,
    output logic [$clog2(COMMIT_WIDTH)-1:0]   evt_lane,
    output logic [CNT_W-1:0]                  evt_time,
    output logic [2:0]                        phase,
    input  logic [2:0]                        rd_phase,
    output logic [CNT_W-1:0]                  rd_cycles,
    output logic                              tsx_done,
    output logic                              sim_exit,
    output logic                              proto_err,
    output logic [CNT_W-1:0]                  drop_cnt
);
    localparam int LANE_W = $clog2(COMMIT_WIDTH);
    localparam int CW_W   = $clog2(COMMIT_WIDTH+1);
    localparam int FR_W   = $clog2(EVQ_DEPTH)+1;
    localparam int DL_W   = $clog2(DONE_DELAY+1);
`ifdef MARKER_TIMESTAMP_EN
    localparam int ENT_W  = 4 + LANE_W + CNT_W;
`else
    localparam int ENT_W  = 4 + LANE_W;
`endif

    phase_e            phase_q, phase_d;
    logic              proto_err_q, proto_err_d, sim_exit_q, sim_exit_d;
    logic              arm_hit, blocked;
    marker_dec_t       dec;
    logic [CW_W-1:0]   n_mk, push_cnt, drop_n;
    logic [ENT_W-1:0]  push_data [COMMIT_WIDTH];
    logic [ENT_W-1:0]  head;
    logic [FR_W-1:0]   free;
    logic [CNT_W-1:0]  drop_q;
    logic [CNT_W:0]    drop_sum;
    logic [CNT_W-1:0]  acc_q [7];
    logic              armed_q, tsx_done_q;
    logic [DL_W-1:0]   dly_q;

`ifdef MARKER_TIMESTAMP_EN
    logic [CNT_W-1:0]  cyc_q, ts_now;
    assign ts_now = cyc_q + CNT_W'(1);

    // Free-running stamp; an event carries the count this edge will reach.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= ts_now;
    end
`endif

    // Walk lanes oldest first; SIM_EXIT blocks every later lane and cycle.
    always_comb begin
        phase_d     = phase_q;
        proto_err_d = proto_err_q;
        sim_exit_d  = sim_exit_q;
        arm_hit     = 1'b0;
        blocked     = sim_exit_q;
        n_mk        = '0;
        dec         = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) push_data[s] = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            dec = marker_decode(commit_inst[32*i +: 32]);
            if (commit_valid[i] && dec.is_marker && !blocked) begin
                for (int s = 0; s < COMMIT_WIDTH; s++) begin
`ifdef MARKER_TIMESTAMP_EN
                    if (n_mk == CW_W'(s)) push_data[s] = {dec.code, LANE_W'(i), ts_now};
`else
                    if (n_mk == CW_W'(s)) push_data[s] = {dec.code, LANE_W'(i)};
`endif
                end
                n_mk = n_mk + CW_W'(1);
                if (dec.code == MK_SIM_EXIT) begin
                    sim_exit_d = 1'b1;
                    blocked    = 1'b1;
                end else if (!dec.code[0]) begin
                    phase_d = phase_e'(dec.code[3:1]);
                end else if (phase_d == phase_e'(dec.code[3:1])) begin
                    phase_d = PHASE_IDLE;
                end else begin
                    proto_err_d = 1'b1;
                end
                if (dec.code == MK_VCTM_END || dec.code == MK_TEXE_START) arm_hit = 1'b1;
            end
        end
    end

    assign push_cnt = (FR_W'(n_mk) > free) ? CW_W'(free) : n_mk;
    assign drop_n   = n_mk - push_cnt;
    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_n);

    // Phase state register and sticky protocol flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q     <= PHASE_IDLE;
            proto_err_q <= 1'b0;
            sim_exit_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            phase_q     <= phase_d;
            proto_err_q <= proto_err_d;
            sim_exit_q  <= sim_exit_d;
            drop_q      <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    // Per-phase cycle accumulators, frozen once the simulation has exited.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 7; p++) acc_q[p] <= '0;
        end else begin
            for (int p = 0; p < 7; p++) begin
                if (!sim_exit_q && phase_q == phase_e'(p)) acc_q[p] <= acc_q[p] + CNT_W'(1);
            end
        end
    end

    // Done countdown: only the first arming marker loads the down-counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q    <= 1'b0;
            dly_q      <= '0;
            tsx_done_q <= 1'b0;
        end else if (arm_hit && !armed_q) begin
            armed_q <= 1'b1;
            if (DONE_DELAY == 1) tsx_done_q <= 1'b1;
            else                 dly_q      <= DL_W'(DONE_DELAY);
        end else if (dly_q != '0) begin
            dly_q <= dly_q - DL_W'(1);
            if (dly_q == DL_W'(1)) tsx_done_q <= 1'b1;
        end
    end

    // Combinational accumulator read; phase 7 has no accumulator and reads 0.
    always_comb begin
        rd_cycles = '0;
        for (int p = 0; p < 7; p++) begin
            if (rd_phase == 3'(p)) rd_cycles = acc_q[p];
        end
    end

    marker_evq #(
        .DEPTH (EVQ_DEPTH),
        .NPUSH (COMMIT_WIDTH),
        .ENT_W (ENT_W)
    ) u_evq (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .pop_i       (evt_ready),
        .valid_o     (evt_valid),
        .head_o      (head),
        .free_o      (free)
    );

`ifdef MARKER_TIMESTAMP_EN
    assign {evt_code, evt_lane, evt_time} = head;
`else
    assign {evt_code, evt_lane} = head;
    assign evt_time = '0;
`endif

    assign phase     = phase_q;
    assign proto_err = proto_err_q;
    assign sim_exit  = sim_exit_q;
    assign drop_cnt  = drop_q;
    assign tsx_done  = tsx_done_q;

endmodule

// File: tb/tb_marker_phase_tracker.sv
// Bench for marker_phase_tracker: a queue-based event model and scoreboard,
// directed scenarios followed by randomized retire traffic.
module tb_marker_phase_tracker;
    localparam int W = 4, DEPTH = 8, DD = 4;

    logic            clock = 1'b0, reset = 1'b1;
    logic [W-1:0]    commit_valid = '0;
    logic [32*W-1:0] commit_inst = '0;
    logic            evt_valid, evt_ready = 1'b0;
    logic [3:0]      evt_code;
    logic [1:0]      evt_lane;
    logic [31:0]     evt_time, rd_cycles, drop_cnt;
    logic [2:0]      phase, rd_phase = 3'd0;
    logic            tsx_done, sim_exit, proto_err;

    marker_phase_tracker dut (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_inst(commit_inst),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_lane(evt_lane),
        .evt_time(evt_time), .phase(phase), .rd_phase(rd_phase), .rd_cycles(rd_cycles),
        .tsx_done(tsx_done), .sim_exit(sim_exit), .proto_err(proto_err), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;

    typedef struct { int code; int lane; int unsigned t; } ev_t;
    ev_t exp_q[$];

    int              m_phase, m_edge, m_arm, m_occ;
    bit              m_err, m_exit;
    longint unsigned m_drop;
    logic [31:0]     m_acc [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int c);
        return {8'h00, 4'(c), 20'h02013};
    endfunction

    task automatic model_reset();
        m_phase = 7; m_edge = 0; m_arm = -1; m_occ = 0;
        m_err = 0; m_exit = 0; m_drop = 0;
        for (int p = 0; p < 8; p++) m_acc[p] = '0;
        exp_q.delete();
    endtask

    // Effect of one clock edge given the inputs about to be sampled.
    task automatic model_edge(input logic [W-1:0] v, input logic [32*W-1:0] insts, input logic rdy);
        int free, popped, nm, code;
        bit blocked;
        logic [31:0] inst;
        int unsigned ts;
        m_edge++;
        free   = DEPTH - m_occ;
        popped = (rdy && m_occ > 0) ? 1 : 0;
        if (m_phase != 7 && !m_exit) m_acc[m_phase] = m_acc[m_phase] + 1;
`ifdef MARKER_TIMESTAMP_EN
        ts = m_edge;
`else
        ts = 0;
`endif
        blocked = m_exit;
        nm = 0;
        for (int l = 0; l < W; l++) begin
            inst = insts[32*l +: 32];
            code = int'((inst >> 20) & 32'hF);
            if (!blocked && v[l] && (inst & 32'h000F_FFFF) == 32'h02013 && (inst >> 24) == 0 && code <= 14) begin
                if (nm < free) exp_q.push_back('{code, l, ts});
                else if (m_drop < 64'hFFFF_FFFF) m_drop++;
                nm++;
                if (code == 14) begin
                    m_exit = 1; blocked = 1;
                end else if (code % 2 == 0) m_phase = code / 2;
                else if (m_phase == code / 2) m_phase = 7;
                else m_err = 1;
                if ((code == 1 || code == 4) && m_arm < 0) m_arm = m_edge;
            end
        end
        m_occ = m_occ - popped + ((nm < free) ? nm : free);
    endtask

    task automatic check_status();
        chk("phase", phase, m_phase);
        chk("proto_err", proto_err, m_err);
        chk("sim_exit", sim_exit, m_exit);
        chk("tsx_done", tsx_done, (m_arm >= 0 && m_edge >= m_arm + DD));
        chk("drop_cnt", drop_cnt, m_drop);
        chk("evt_valid", evt_valid, m_occ > 0);
        chk("rd_cycles", rd_cycles, m_acc[rd_phase]);
    endtask

    task automatic step(input logic [W-1:0] v, input logic [32*W-1:0] insts, input logic rdy, input logic [2:0] rd);
        @(negedge clock); #2;
        check_status();
        commit_valid = v; commit_inst = insts; evt_ready = rdy; rd_phase = rd;
        model_edge(v, insts, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step('0, '0, rdy, 3'($urandom_range(0, 7)));
    endtask

    task automatic do_reset();
        @(negedge clock); #2;
        check_status();
        reset = 1'b1; commit_valid = '0; evt_ready = 1'b0; rd_phase = 3'd4;
        #1;
        chk("rst_phase", phase, 7);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_fields", {evt_code, evt_lane, evt_time}, 0);
        chk("rst_flags", {tsx_done, sim_exit, proto_err}, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_rd_cycles", rd_cycles, 0);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: compares the head whenever the sink accepts it.
    initial begin
        forever begin
            @(negedge clock); #3;
            if (!reset) begin
                if (evt_valid && evt_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_evt", evt_valid, 0);
                    else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        chk("evt_code", evt_code, e.code);
                        chk("evt_lane", evt_lane, e.lane);
                        chk("evt_time", evt_time, e.t);
                    end
                end else if (!evt_valid) begin
                    chk("empty_fields", {evt_code, evt_lane, evt_time}, 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32*W-1:0] insts;
        logic [W-1:0] v;
        logic rdy;
        model_reset();
        do_reset();

        // INIT phase opened at edge 5, closed at edge 15.
        idle(4, 1'b0);
        step(4'b0100, {32'h0, 32'h00802013, 64'h0}, 1'b0, 3'd0);
        idle(9, 1'b0);
        step(4'b0001, {96'h0, 32'h00902013}, 1'b0, 3'd0);
        step('0, '0, 1'b0, 3'd4); #1;
        chk("t1_phase", phase, 7);
        chk("t1_rd_cycles", rd_cycles, 10);
        chk("t1_head_code", evt_code, 8);
        chk("t1_head_lane", evt_lane, 2);

        // Last marker wins within a cycle; lone END while idle is an error.
        step(4'hF, {mk(11), 32'h00000013, mk(10), mk(12)}, 1'b1, 3'd6);
        step('0, '0, 1'b1, 3'd5); #1;
        chk("t2_phase", phase, 7);
        chk("t2_proto_err", proto_err, 0);
        step(4'b0010, {64'h0, mk(5), 32'h0}, 1'b1, 3'd0);
        step('0, '0, 1'b1, 3'd0); #1;
        chk("t2_proto_err_end", proto_err, 1);

        // VCTM_END arms the done countdown.
        step(4'b0001, {96'h0, mk(1)}, 1'b1, 3'd0);
        for (int j = 1; j <= 5; j++) begin
            step('0, '0, 1'b1, 3'd0); #1;
            chk("t3_tsx_done", tsx_done, j >= 5);
        end
        step(4'b0001, {96'h0, mk(1)}, 1'b1, 3'd0);
        idle(3, 1'b1);

        // Overflow: 12 markers into an 8-entry queue, then drain.
        idle(12, 1'b1);
        for (int j = 0; j < 3; j++)
            step(4'hF, {mk(j*4+3), mk(j*4+2), mk(j*4+1), mk(j*4)}, 1'b0, 3'd0);
        step('0, '0, 1'b0, 3'd0); #1;
        chk("t4_drop_cnt", drop_cnt, 4);
        chk("t4_evt_valid", evt_valid, 1);
        idle(12, 1'b1);

        // Reset mid-countdown with a half-full queue, then timestamp of edge 9.
        do_reset();
        step(4'b0001, {96'h0, mk(4)}, 1'b0, 3'd2);
        step(4'hF, {mk(6), mk(2), mk(0), mk(12)}, 1'b0, 3'd3);
        step('0, '0, 1'b0, 3'd0);
        do_reset();
        idle(8, 1'b0);
        step(4'b0010, {64'h0, mk(2), 32'h0}, 1'b0, 3'd1);
        step('0, '0, 1'b0, 3'd1); #1;
`ifdef MARKER_TIMESTAMP_EN
        chk("t6_evt_time", evt_time, 9);
`else
        chk("t6_evt_time", evt_time, 0);
`endif
        chk("t6_tsx_done", tsx_done, 0);

        // Randomized retire traffic without SIM_EXIT.
        for (int k = 0; k < 400; k++) begin
            for (int l = 0; l < W; l++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: insts[32*l +: 32] = mk($urandom_range(0, 13));
                    6:                insts[32*l +: 32] = mk(15);
                    7:                insts[32*l +: 32] = $urandom;
                    8:                insts[32*l +: 32] = {8'(1 + $urandom_range(0, 254)), 4'($urandom_range(0, 13)), 20'h02013};
                    default:          insts[32*l +: 32] = 32'h00000013;
                endcase
            end
            v   = 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0) && ((k / 40) % 3 != 2);
            step(v, insts, rdy, 3'($urandom_range(0, 7)));
        end
        idle(12, 1'b1);

        // SIM_EXIT blocks later lanes, later cycles and accumulation.
        step(4'b0111, {32'h0, mk(9), mk(14), mk(8)}, 1'b0, 3'd4);
        step('0, '0, 1'b0, 3'd4); #1;
        chk("t5_sim_exit", sim_exit, 1);
        chk("t5_phase", phase, 4);
        step(4'b0001, {96'h0, mk(0)}, 1'b0, 3'd4);
        for (int j = 0; j < 5; j++) step('0, '0, 1'b0, 3'd4);
        idle(12, 1'b1);
        step('0, '0, 1'b1, 3'd0);
        chk("leftover_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
